icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-side responder for the fetch stage's inst_read/inst_resp handshake.
- Direct-mapped, read-only instruction cache. Returns 32-bit instructions on hit in the request cycle.
- On miss, fills a 256-bit line from physical memory using the pmem_read/pmem_resp handshake.
- Sits between the fetch stage and the memory arbiter. Also supports whole-cache invalidate for fence.i.

Parameters:
- S_INDEX, 4, set-index width; sets = 2**S_INDEX (16).
- S_OFFSET, 5, line byte-offset width; line = 256 bits, 8 words. Fixed; not overridable.
- S_TAG, 32-S_INDEX-S_OFFSET (23), tag width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- inst_read  in  1  fetch request; held with inst_addr stable until inst_resp.
- inst_addr  in  32  fetch byte address; [1:0] ignored.
- inst_resp  out  1  single-cycle response strobe.
- inst_rdata  out  32  instruction; valid only while inst_resp=1.
- inv  in  1  invalidate-all pulse.
- pmem_read  out  1  line-fill request; held until pmem_resp.
- pmem_address  out  32  line-aligned fill address; [4:0]=0.
- pmem_rdata  in  256  fill data; word k at bits [32k+31:32k].
- pmem_resp  in  1  fill complete; single cycle; pmem_rdata valid this cycle.

Behaviour:
- Address split: tag=addr[31:9], index=addr[8:5], word=addr[4:2].
- Storage per set: valid bit, tag, 256-bit data line. Combinational read; write at clock edge.
- State IDLE:
  - inst_read=1 with valid[index] and tag match (hit): inst_resp=1 in the same cycle.
  - On hit, inst_rdata = line[index] word selected by addr[4:2]. State stays IDLE, so back-to-back hits give 1 instruction per cycle.
  - inst_read=1 and miss: register fill_addr={addr[31:5],5'b0}, go to FETCH. inst_resp=0.
  - inst_read=0: no action.
- State FETCH:
  - pmem_read=1 and pmem_address=fill_addr for every cycle; inst_resp=0; inst_addr ignored.
  - On pmem_resp: write data/tag, set valid for fill_addr's set (overwrite, no writeback), then go to IDLE.
  - The next IDLE cycle re-performs the lookup. Miss-to-resp latency = pmem latency + 1 cycle.
- Requester drops inst_read (stall) mid-fill: fill still completes and installs. No response is owed.
- inv=1: all valid bits clear at the next edge. No effect on state.
  - inv in the same cycle as a hit: hit response is still given (lookup precedes clear).
  - inv in the same cycle as pmem_resp: inv wins. Line is written but not marked valid. FSM still returns to IDLE.
  - inv during FETCH before pmem_resp: the later fill installs normally.
- Reset (rst=0 at edge):
  - state=IDLE, all valid=0, fill_addr=0.
  - Outputs: inst_resp=0, pmem_read=0, pmem_address=0, inst_rdata=0.
  - Reset mid-FETCH abandons the fill. Arbiter must tolerate pmem_read dropping; a pmem_resp arriving after reset is ignored.
- Tag/data arrays need not be reset; only valid bits are.
- No outputs are driven X. inst_rdata=0 whenever inst_resp=0.

Decomposition:
- Shared package cache_types holds:
  - icache_state_t enum {IDLE, FETCH}
  - line width constant (256)
  - S_INDEX/S_OFFSET defaults
  - the addr-split helper widths.
- One sub-module: icache_array. It holds the valid/tag/data arrays with combinational read, a single write port (index, tag, line, set_valid) and invalidate-all. Top level holds the FSM, hit compare, word mux and fill_addr register.

Test Plan:
- Cold miss: after reset, inst_read=1, inst_addr=0x0000006C.
  - Expect: next cycle pmem_read=1, pmem_address=0x00000060.
  - pmem_resp 5 cycles later with word3=0x00000013.
  - Expect: next cycle inst_resp=1, inst_rdata=0x00000013.
- Streaming hits: after fill, addresses 0x60, 0x64, ..., 0x7C on consecutive cycles.
  - Expect: inst_resp=1 every cycle, pmem_read stays 0, correct words 0-7.
- Conflict eviction: fill 0x60, then read 0x260 (same index 3).
  - Expect: miss, pmem_address=0x00000260.
  - Then re-read 0x60: miss again, pmem_address=0x00000060.
- Stall mid-fill: miss on 0x100, drop inst_read 2 cycles later, pmem_resp arrives.
  - Expect: no inst_resp.
  - Later read 0x104: hit in the same cycle, no pmem_read.
- Invalidate race: inv=1 in the same cycle as pmem_resp for 0x40.
  - Expect: return to IDLE, then a read of 0x40 misses again.
  - Separately, inv during a hit cycle still gives inst_resp=1; the next read of that address misses.
- Reset mid-fill: rst=0 while pmem_read=1.
  - Expect: after the edge pmem_read=0, state IDLE.
  - A late pmem_resp is ignored; a previously cached address misses.

Source files
------------

// File: rtl/cache_types.sv
// ============================================================================
// cache_types : shared types and address-split widths for the icache slice
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cache_types;
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    localparam int ADDR_W          = 32;
    localparam int WORD_W          = 32;
    localparam int LINE_W          = 256;
    localparam int S_INDEX_DEFAULT = 4;
    localparam int S_OFFSET        = 5;
    localparam int WORD_SEL_W      = S_OFFSET - 2;

    function automatic int tag_width(input int s_index);
        return ADDR_W - s_index - S_OFFSET;
    endfunction
endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// icache_array : valid/tag/data storage, combinational read, one write port
// Revision     : 1.0
// ============================================================================
`default_nettype none

module icache_array
    import cache_types::*;
#(
    parameter int S_INDEX = S_INDEX_DEFAULT,
    parameter int S_TAG   = tag_width(S_INDEX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] rd_index,
    output logic               rd_valid,
    output logic [S_TAG-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_index,
    input  logic [S_TAG-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic               wr_set_valid,
    input  logic               inv
);
    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]   valid;
    logic [S_TAG-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];

    // Invalidate beats a concurrent fill: the line lands but stays invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (wr_en && wr_set_valid) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];
endmodule

`default_nettype wire

// File: rtl/icache_responder.sv
// ============================================================================
// icache_responder : direct-mapped read-only instruction cache with line fill
// Revision         : 1.0
// ============================================================================
`default_nettype none

module icache_responder
    import cache_types::*;
#(
    parameter int S_INDEX = S_INDEX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read,
    input  logic [31:0]       inst_addr,
    output logic              inst_resp,
    output logic [31:0]       inst_rdata,
    input  logic              inv,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int S_TAG = tag_width(S_INDEX);

    icache_state_t         state;
    logic [31:0]           fill_addr;

    logic [S_TAG-1:0]      req_tag;
    logic [S_INDEX-1:0]    req_index;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  rd_valid;
    logic [S_TAG-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  hit;
    logic                  fill_done;
    logic                  unused_addr_bits;

    assign req_tag          = inst_addr[ADDR_W-1 -: S_TAG];
    assign req_index        = inst_addr[S_OFFSET +: S_INDEX];
    assign req_word         = inst_addr[S_OFFSET-1:2];
    assign unused_addr_bits = ^inst_addr[1:0];

    assign fill_done = (state == FETCH) && pmem_resp;

    icache_array #(
        .S_INDEX (S_INDEX),
        .S_TAG   (S_TAG)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (req_index),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_line      (rd_line),
        .wr_en        (fill_done),
        .wr_index     (fill_addr[S_OFFSET +: S_INDEX]),
        .wr_tag       (fill_addr[ADDR_W-1 -: S_TAG]),
        .wr_line      (pmem_rdata),
        .wr_set_valid (!inv),
        .inv          (inv)
    );

    // Gated by rst so nothing stale can answer while reset is asserted.
    assign hit        = rd_valid && (rd_tag == req_tag);
    assign inst_resp  = rst && (state == IDLE) && inst_read && hit;
    assign inst_rdata = inst_resp ? rd_line[{req_word, 5'b00000} +: WORD_W] : '0;

    assign pmem_address = fill_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pmem_read <= 1'b0;
            fill_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_read && !hit) begin
                        fill_addr <= {inst_addr[ADDR_W-1:S_OFFSET], {S_OFFSET{1'b0}}};
                        pmem_read <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    pmem_read <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_icache_responder.sv
// ============================================================================
// tb_icache_responder : scoreboard bench with a memory model and cache model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_icache_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inst_read = 1'b0;
    logic [31:0]  inst_addr = '0;
    logic         inst_resp;
    logic [31:0]  inst_rdata;
    logic         inv = 1'b0;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    bit          mv[16];
    logic [22:0] mt[16];
    bit          auto_resp = 1'b1;
    int          forced_lat = 0;
    int          last_lat = 0;
    logic [31:0] exp_fill = '0;

    icache_responder dut (
        .clk          (clk),
        .rst          (rst),
        .inst_read    (inst_read),
        .inst_addr    (inst_addr),
        .inst_resp    (inst_resp),
        .inst_rdata   (inst_rdata),
        .inv          (inv),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_006C) return 32'h0000_0013;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word({base[31:5], 5'b0} + 32'(4*k));
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[8:5]] && (mt[a[8:5]] == a[31:9]);
    endfunction

    function automatic void model_install(input logic [31:0] a);
        mv[a[8:5]] = 1'b1;
        mt[a[8:5]] = a[31:9];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endfunction

    // Monitor: every response is popped against the scoreboard queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (inst_resp === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {31'b0, inst_resp}, 32'h0);
                end else begin
                    check("inst_rdata", inst_rdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle_zero", inst_rdata, 32'h0);
            end
        end
    end

    // Memory model answering fills after a chosen latency.
    initial begin
        int lat;
        forever begin
            @(posedge clk); #1;
            if (auto_resp && rst && pmem_read) begin
                lat = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 6));
                last_lat = lat;
                check("pmem_address", pmem_address, exp_fill);
                repeat (lat - 1) begin
                    @(posedge clk); #1;
                end
                pmem_rdata = line_of(pmem_address);
                pmem_resp  = 1'b1;
                @(posedge clk); #1;
                pmem_resp  = 1'b0;
                pmem_rdata = {8{$urandom}};
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        bit hit;
        int n;
        hit = model_hit(a);
        if (!hit) exp_fill = {a[31:5], 5'b0};
        inst_addr = a;
        inst_read = 1'b1;
        exp_q.push_back(mem_word(a));
        n = 0;
        forever begin
            @(negedge clk);
            if (inst_resp === 1'b1) break;
            n++;
            if (n > 40) begin
                check("resp_timeout", 32'(n), 32'h0);
                void'(exp_q.pop_back());
                break;
            end
        end
        check("pmem_read_at_resp", {31'b0, pmem_read}, 32'h0);
        if (n <= 40) begin
            if (hit) check("hit_latency", 32'(n), 32'h0);
            else     check("miss_latency", 32'(n), 32'(last_lat + 1));
        end
        model_install(a);
        @(posedge clk); #1;
        inst_read = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        tick(); tick();
        @(negedge clk);
        check("rst_inst_resp", {31'b0, inst_resp}, 32'h0);
        check("rst_pmem_read", {31'b0, pmem_read}, 32'h0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_inst_rdata", inst_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Cold miss and streaming hits through the whole line.
        forced_lat = 5;
        fetch(32'h0000_006C);
        forced_lat = 0;
        for (int i = 0; i < 8; i++) fetch(32'h0000_0060 + 32'(4*i));

        // Conflict eviction on set 3.
        fetch(32'h0000_0260);
        fetch(32'h0000_0060);

        // Requester stalls mid-fill.
        auto_resp = 1'b0;
        inst_addr = 32'h0000_0100;
        inst_read = 1'b1;
        @(negedge clk);
        check("stall_no_resp", {31'b0, inst_resp}, 32'h0);
        tick();
        @(negedge clk);
        check("stall_pmem_read", {31'b0, pmem_read}, 32'h1);
        check("stall_pmem_addr", pmem_address, 32'h0000_0100);
        tick();
        inst_read = 1'b0;
        tick();
        pmem_rdata = line_of(32'h0000_0100);
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
        model_install(32'h0000_0100);
        tick(); tick();
        auto_resp = 1'b1;
        fetch(32'h0000_0104);

        // Invalidate racing a fill completion.
        auto_resp = 1'b0;
        inst_addr = 32'h0000_0040;
        inst_read = 1'b1;
        tick(); tick();
        inst_read  = 1'b0;
        pmem_rdata = line_of(32'h0000_0040);
        pmem_resp  = 1'b1;
        inv        = 1'b1;
        tick();
        pmem_resp = 1'b0;
        inv       = 1'b0;
        model_clear();
        @(negedge clk);
        check("inv_race_idle", {31'b0, pmem_read}, 32'h0);
        tick();
        auto_resp = 1'b1;
        fetch(32'h0000_0040);

        // Invalidate in a hit cycle: the hit still answers.
        inst_addr = 32'h0000_0044;
        inst_read = 1'b1;
        inv       = 1'b1;
        exp_q.push_back(mem_word(32'h0000_0044));
        @(negedge clk);
        check("inv_hit_resp", {31'b0, inst_resp}, 32'h1);
        tick();
        inst_read = 1'b0;
        inv       = 1'b0;
        model_clear();
        fetch(32'h0000_0044);

        // Reset abandons a fill; a late response is ignored.
        fetch(32'h0000_0080);
        auto_resp = 1'b0;
        inst_addr = 32'h0000_00A0;
        inst_read = 1'b1;
        tick();
        @(negedge clk);
        check("pre_rst_pmem_read", {31'b0, pmem_read}, 32'h1);
        tick();
        inst_read = 1'b0;
        rst       = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_pmem_read", {31'b0, pmem_read}, 32'h0);
        check("post_rst_pmem_addr", pmem_address, 32'h0);
        tick();
        pmem_rdata = line_of(32'h0000_00A0);
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("late_resp_ignored", {31'b0, pmem_read}, 32'h0);
        tick();
        model_clear();
        auto_resp = 1'b1;
        fetch(32'h0000_0080);
        fetch(32'h0000_00A0);

        // Randomized traffic over a few conflicting tags.
        for (int it = 0; it < 250; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                inv = 1'b1;
                tick();
                inv = 1'b0;
                model_clear();
            end else if (r == 1) begin
                tick();
            end else begin
                fetch({21'b0, 2'($urandom), 4'($urandom), 3'($urandom), 2'($urandom)});
            end
        end

        tick(); tick();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
